// File: rtl/branch_resolve_pkg.sv
// Shared encodings for the EX-stage branch resolution unit: comparator results,
// branch funct3 codes and FSM states.
package branch_resolve_pkg;

    localparam logic [1:0] CMP_GT = 2'b00;
    localparam logic [1:0] CMP_LT = 2'b01;
    localparam logic [1:0] CMP_EQ = 2'b10;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StRedirect,
        StFlush
    } state_e;

endpackage

// File: rtl/branch_resolve_if.sv
// Redirect channel from the branch resolution unit to fetch (valid/ready handshake).
interface branch_resolve_if #(
    parameter int unsigned XLEN = 32
);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect_ready;

    modport master (
        output redirect_valid,
        output redirect_pc,
        input  redirect_ready
    );

    modport slave (
        input  redirect_valid,
        input  redirect_pc,
        output redirect_ready
    );
endinterface

// File: rtl/branch_taken_decode.sv
// Combinational taken decision from jump flags, branch funct3 and comparator result.
// Jumps always win over a conditional branch; illegal funct3 codes never take.
module branch_taken_decode
    import branch_resolve_pkg::*;
(
    input  logic       is_branch,
    input  logic       is_jal,
    input  logic       is_jalr,
    input  logic [2:0] funct3,
    input  logic [1:0] branch_type,
    output logic       taken
);

    logic eq;
    logic lt;

    always_comb begin
        eq    = (branch_type == CMP_EQ);
        lt    = (branch_type == CMP_LT);
        taken = 1'b0;
        if (is_jalr || is_jal) begin
            taken = 1'b1;
        end else if (is_branch) begin
            case (funct3)
                BEQ:        taken = eq;
                BNE:        taken = ~eq;
                BLT, BLTU:  taken = lt;
                BGE, BGEU:  taken = ~lt;
                default:    taken = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch/jump resolution: registered PC redirect to fetch plus a fixed-length
// flush of younger instructions. Define BRANCH_RESOLVE_STATS_EN to add statistics counters.
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_valid,
    input  logic                ex_stall,
    input  logic                is_branch,
    input  logic                is_jal,
    input  logic                is_jalr,
    input  logic [2:0]          funct3,
    input  logic [1:0]          branch_type,
    input  logic [XLEN-1:0]     target,
    output logic                branch_unsigned,
    branch_resolve_if.master    redir,
    output logic                flush,
`ifdef BRANCH_RESOLVE_STATS_EN
    output logic [CNT_W-1:0]    stat_branches,
    output logic [CNT_W-1:0]    stat_taken,
    output logic [CNT_W-1:0]    stat_jumps,
`endif
    output logic                taken
);

    localparam logic [3:0] FlushInit = 4'(FLUSH_CYCLES) - 4'd1;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            fire;

    branch_taken_decode u_decode (
        .is_branch   (is_branch),
        .is_jal      (is_jal),
        .is_jalr     (is_jalr),
        .funct3      (funct3),
        .branch_type (branch_type),
        .taken       (taken)
    );

    assign branch_unsigned = funct3[1];
    assign fire            = ex_valid & ~ex_stall & (state_q == StIdle);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        unique case (state_q)
            StIdle: begin
                if (fire && taken) begin
                    state_d = StRedirect;
                    pc_d    = is_jalr ? {target[XLEN-1:1], 1'b0} : target;
                end
            end
            StRedirect: begin
                if (redir.redirect_ready) begin
                    if (FLUSH_CYCLES == 0) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StFlush;
                        cnt_d   = FlushInit;
                    end
                end
            end
            StFlush: begin
                if (cnt_q == 4'd0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
        end
    end

    // Outputs decode registered state only, so fetch never sees an input->redirect path.
    assign redir.redirect_valid = (state_q == StRedirect);
    assign redir.redirect_pc    = pc_q;
    assign flush                = (state_q != StIdle);

`ifdef BRANCH_RESOLVE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches <= '0;
            stat_taken    <= '0;
            stat_jumps    <= '0;
        end else if (fire) begin
            if (is_branch) stat_branches <= stat_branches + 1'b1;
            if (is_branch && taken) stat_taken <= stat_taken + 1'b1;
            if (is_jal || is_jalr) stat_jumps <= stat_jumps + 1'b1;
        end
    end
`endif

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- EX-stage branch/jump resolution unit of the pipelined RV32I core.
- Sits directly downstream of the branch comparator:
  - drives the comparator's unsigned-select from funct3;
  - consumes its 2-bit compare result (00 = a>b, 01 = a<b, 10 = equal).
- Decides taken/not-taken, issues a registered PC redirect to fetch with a ready handshake, and sequences a fixed-length flush of younger IF/ID instructions.
- Fetch is static predict-not-taken, so every taken branch or jump redirects.

Parameters:
- XLEN, 32, datapath/PC width
- FLUSH_CYCLES, 2, younger-instruction kill cycles after redirect accepted (0..15)
- CNT_W, 32, statistics counter width (used only with the optional feature)

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- ex_valid  input  1  EX holds a live instruction
- ex_stall  input  1  EX frozen this cycle; no resolution
- is_branch  input  1  conditional branch in EX
- is_jal  input  1  JAL in EX
- is_jalr  input  1  JALR in EX
- funct3  input  3  branch funct3
- branch_type  input  2  comparator result
- target  input  XLEN  ALU-computed target
- branch_unsigned  output  1  to comparator; funct3[1] (combinational)
- redirect_valid  output  1  redirect request to fetch
- redirect_pc  output  XLEN  new fetch PC
- redirect_ready  input  1  fetch accepts redirect
- flush  output  1  kill IF/ID contents and EX-input bubble
- taken  output  1  combinational resolve result, for debug/trace

Behaviour:
- Reset state: IDLE; redirect_valid=0, redirect_pc=0, flush=0, internal flush counter=0.
- Resolve term `fire` = ex_valid & ~ex_stall & state==IDLE.
- Taken decode:
  - is_jal | is_jalr -> 1.
  - is_branch by funct3:
    - 000 eq
    - 001 ~eq
    - 100/110 lt
    - 101/111 ~lt
    - 010/011 -> 0 (illegal; never redirect)
  - eq = (branch_type==10); lt = (branch_type==01); branch_type==11 treated as not-eq, not-lt.
  - Priority when several flags are set: jalr > jal > branch.
- Target handling: redirect_pc = is_jalr ? {target[XLEN-1:1],0} : target; latched at the fire edge.
- FSM states:
  - IDLE: fire & taken -> REDIRECT, with redirect_valid=1 and flush=1 from the next cycle (1-cycle latency). Otherwise stay.
  - REDIRECT: redirect_valid=1, flush=1; redirect_pc held stable.
    - redirect_ready=1 -> FLUSH with counter=FLUSH_CYCLES-1; if FLUSH_CYCLES==0, go straight to IDLE.
    - redirect_ready=0 -> hold, no timeout.
  - FLUSH: redirect_valid=0, flush=1; counter decrements; at 0 -> IDLE on the next edge.
- Mid-operation events:
  - In REDIRECT/FLUSH, ex_valid and all instruction inputs are ignored (the instruction is a killed younger one). No second redirect is possible until IDLE.
  - ex_stall in IDLE suppresses fire, so a stalled taken branch redirects exactly once, on its first unstalled cycle.
  - ex_stall in REDIRECT/FLUSH has no effect on the FSM.
  - rst in any state returns to IDLE with outputs cleared on the next edge; a pending redirect is dropped.
- Back-to-back taken: instruction N taken, N+1 arrives in EX during FLUSH -> ignored. The next IDLE-cycle instruction may fire.
- redirect_valid and redirect_pc are registered outputs; no combinational input->redirect path. `taken` is combinational.

Optional Feature:
- Macro: BRANCH_RESOLVE_STATS_EN.
- With the macro defined, adds output ports:
  - stat_branches  output  CNT_W  increments on fire & is_branch
  - stat_taken  output  CNT_W  increments on fire & is_branch & taken
  - stat_jumps  output  CNT_W  increments on fire & (is_jal|is_jalr)
  - All counters reset to 0 and wrap modulo 2^CNT_W.
- Without it: no counter ports, no counter logic.

Decomposition:
- Shared package: branch_type encodings (CMP_GT=2'b00, CMP_LT=2'b01, CMP_EQ=2'b10); funct3 constants BEQ/BNE/BLT/BGE/BLTU/BGEU; FSM state encodings.
- One sub-module, branch_taken_decode: combinational funct3 + branch_type + jump flags -> taken.
- FSM and counters stay in the top.

Test Plan:
- BEQ (funct3=000), branch_type=10, target=0x0000_1000, ready=1:
  - redirect_valid=1 one cycle after fire, redirect_pc=0x1000;
  - flush high for 1+2 cycles, then IDLE.
- BLTU (110), branch_type=00: taken=0, branch_unsigned=1, no redirect, flush stays 0. Repeat with branch_type=01 -> redirect.
- JALR with target=0x0000_2003: redirect_pc=0x0000_2002.
- Taken BNE with redirect_ready held 0 for 4 cycles:
  - redirect_valid and redirect_pc stable for all 4 cycles;
  - a taken JAL presented meanwhile is ignored;
  - FLUSH starts after ready rises.
- Taken branch under ex_stall=1 for 3 cycles, then stall released: exactly one redirect, in the cycle after release. rst asserted during REDIRECT: all outputs 0 on the next edge.
- With BRANCH_RESOLVE_STATS_EN, 5 branches (3 taken) and 2 jumps:
  - stat_branches=5, stat_taken=3, stat_jumps=2.
  - With CNT_W=4: 17 branches -> stat_branches=1.
